// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: opcodes, functs,
// FSM states and ALU operation encoding.
package cpu_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } stateT;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } aluOpT;

    function automatic logic functLegal(input logic [5:0] funct);
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic aluOpT functToAluOp(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: wraparound add/sub, bitwise and/or, signed set-less-than.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  aluOpT             op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    logic signed [DATA_W-1:0] aSigned;
    logic signed [DATA_W-1:0] bSigned;

    assign aSigned = a;
    assign bSigned = b;

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, (aSigned < bSigned)};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset core with a single unified memory port; holds the
// register file, control FSM and datapath registers.
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter bit          ILLEGAL_HALTS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              halted,
    output logic              illegal
);

    stateT state, nextState;

    logic [DATA_W-1:0] pc, ir, regA, regB, aluOut, mdr;
    logic [DATA_W-1:0] regFile [32];
    logic              illegalQ;

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd, wbDest;
    logic signed [DATA_W-1:0] immExt;
    logic opLegal;

    aluOpT             aluOp;
    logic [DATA_W-1:0] aluB, aluResult;
    logic              aluZero;

    logic              reqRaw, weRaw;
    logic [DATA_W-1:0] addrRaw;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign funct  = ir[5:0];
    assign immExt = {{(DATA_W-16){ir[15]}}, ir[15:0]};
    assign wbDest = (opcode == OP_RTYPE) ? rd : rt;

    always_comb begin
        opLegal = 1'b0;
        case (opcode)
            OP_RTYPE:                                   opLegal = functLegal(funct);
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_HALT: opLegal = 1'b1;
            default:                                    opLegal = 1'b0;
        endcase
    end

    // Address arithmetic (addi/lw/sw) shares the ALU adder with the immediate.
    always_comb begin
        aluOp = ALU_ADD;
        aluB  = immExt;
        if (opcode == OP_RTYPE) begin
            aluOp = functToAluOp(funct);
            aluB  = regB;
        end else if (opcode == OP_BEQ) begin
            aluOp = ALU_SUB;
            aluB  = regB;
        end
    end

    cpu_alu uAlu (
        .a      (regA),
        .b      (aluB),
        .op     (aluOp),
        .result (aluResult),
        .zero   (aluZero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        reqRaw    = 1'b0;
        weRaw     = 1'b0;
        addrRaw   = pc;
        case (state)
            S_FETCH: begin
                reqRaw = 1'b1;
                if (mem_ack) nextState = S_DECODE;
            end
            S_DECODE: begin
                if (!opLegal)              nextState = ILLEGAL_HALTS ? S_HALT : S_FETCH;
                else if (opcode == OP_J)    nextState = S_FETCH;
                else if (opcode == OP_HALT) nextState = S_HALT;
                else                        nextState = S_EXEC;
            end
            S_EXEC: begin
                if (opcode == OP_BEQ)                         nextState = S_FETCH;
                else if (opcode == OP_LW || opcode == OP_SW)  nextState = S_MEM;
                else                                          nextState = S_WB;
            end
            S_MEM: begin
                reqRaw  = 1'b1;
                weRaw   = (opcode == OP_SW);
                addrRaw = aluOut;
                if (mem_ack) nextState = (opcode == OP_SW) ? S_FETCH : S_WB;
            end
            S_WB:    nextState = S_FETCH;
            S_HALT:  nextState = S_HALT;
            default: nextState = S_FETCH;
        endcase
    end

    // Reset withdraws a pending request in the same cycle it is asserted.
    assign mem_req   = reqRaw & ~rst;
    assign mem_we    = weRaw & ~rst;
    assign mem_addr  = addrRaw;
    assign mem_wdata = regB;
    assign halted    = (state == S_HALT);
    assign illegal   = illegalQ;
    assign dbg_data  = regFile[dbg_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir       <= '0;
            regA     <= '0;
            regB     <= '0;
            aluOut   <= '0;
            mdr      <= '0;
            illegalQ <= 1'b0;
            for (int i = 0; i < 32; i++) regFile[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata;
                        pc <= pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    regA <= regFile[rs];
                    regB <= regFile[rt];
                    if (opcode == OP_J) pc <= {pc[31:28], ir[25:0], 2'b00};
                    if (!opLegal && ILLEGAL_HALTS) illegalQ <= 1'b1;
                end
                S_EXEC: begin
                    aluOut <= aluResult;
                    if (opcode == OP_BEQ && aluZero) pc <= pc + {immExt[DATA_W-3:0], 2'b00};
                end
                S_MEM: begin
                    if (mem_ack && opcode == OP_LW) mdr <= mem_rdata;
                end
                S_WB: begin
                    if (wbDest != 5'd0) regFile[wbDest] <= (opcode == OP_LW) ? mdr : aluOut;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed self-checking bench for multicycle_cpu with a wait-state memory model.
module tb_multicycle_cpu;

    localparam logic [5:0] OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24;
    localparam logic [5:0] FN_OR = 6'h25, FN_SLT = 6'h2A;
    localparam logic [31:0] HALT_W = 32'hFC00_0000;
    localparam logic [31:0] ILL_W  = 32'hF800_0000;
    localparam int BASE = 16;

    logic clk, rst;
    logic memReq, memWe, memAck, halted, illegal;
    logic [31:0] memAddr, memWdata, memRdata, dbgData;
    logic [4:0] dbgAddr;
    logic memReq2, memWe2, halted2, illegal2;
    logic [31:0] memAddr2, memWdata2, memRdata2, dbgData2;
    logic [4:0] dbgAddr2;

    logic [31:0] prog [0:63];
    logic [31:0] dmem [0:63];
    logic [63:0] dvld;
    int ackDelay, waitCnt, wrCount;
    logic forceAck;
    logic [31:0] lastWrAddr, lastWrData;

    int total = 0;
    int bad = 0;

    multicycle_cpu #(.RESET_PC(32'h0000_0040), .ILLEGAL_HALTS(1'b1)) dut (
        .clk(clk), .rst(rst), .mem_req(memReq), .mem_we(memWe), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_rdata(memRdata), .mem_ack(memAck),
        .dbg_addr(dbgAddr), .dbg_data(dbgData), .halted(halted), .illegal(illegal)
    );

    multicycle_cpu #(.RESET_PC(32'h0000_0040), .ILLEGAL_HALTS(1'b0)) dutNop (
        .clk(clk), .rst(rst), .mem_req(memReq2), .mem_we(memWe2), .mem_addr(memAddr2),
        .mem_wdata(memWdata2), .mem_rdata(memRdata2), .mem_ack(memReq2),
        .dbg_addr(dbgAddr2), .dbg_data(dbgData2), .halted(halted2), .illegal(illegal2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memAck    = (memReq && (waitCnt >= ackDelay)) || forceAck;
    assign memRdata  = dvld[memAddr[7:2]] ? dmem[memAddr[7:2]] : prog[memAddr[7:2]];
    assign memRdata2 = prog[memAddr2[7:2]];

    always_ff @(posedge clk) begin
        if (memReq && !memAck) waitCnt <= waitCnt + 1;
        else                   waitCnt <= 0;
        if (rst) begin
            dvld    <= '0;
            wrCount <= 0;
        end else if (memReq && memAck && memWe) begin
            dmem[memAddr[7:2]] <= memWdata;
            dvld[memAddr[7:2]] <= 1'b1;
            wrCount    <= wrCount + 1;
            lastWrAddr <= memAddr;
            lastWrData <= memWdata;
        end
    end

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clearProg();
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    endtask

    task automatic resetCore();
        rst = 1'b1;
        forceAck = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runUntilHalt(input int maxCyc, output int cyc);
        cyc = 0;
        while (!halted && cyc < maxCyc) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic readReg(input logic [4:0] r, output logic [31:0] v);
        dbgAddr = r;
        #1 v = dbgData;
    endtask

    task automatic readReg2(input logic [4:0] r, output logic [31:0] v);
        dbgAddr2 = r;
        #1 v = dbgData2;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        ackDelay = 0;
        clearProg();
        prog[BASE] = HALT_W;
        rst = 1'b1;
        forceAck = 1'b0;
        @(posedge clk);
        #1;
        total++; if (memReq !== 1'b0) begin bad++; $display("FAIL reset_memreq got=%b want=0", memReq); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal); end
        readReg(5'd31, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_r31 got=%h want=0", v); end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        total++; if (memReq !== 1'b1 || memWe !== 1'b0) begin bad++; $display("FAIL reset_first_fetch req=%b we=%b want req=1 we=0", memReq, memWe); end
        total++; if (memAddr !== 32'h40) begin bad++; $display("FAIL reset_fetch_addr got=%h want=40", memAddr); end
    endtask

    task automatic test_alu_prog();
        int cyc;
        logic [31:0] v;
        ackDelay = 0;
        clearProg();
        prog[BASE+0] = encI(OP_ADDI, 5'd0, 5'd1, 16'd5);
        prog[BASE+1] = encI(OP_ADDI, 5'd0, 5'd2, 16'd7);
        prog[BASE+2] = encR(5'd1, 5'd2, 5'd3, FN_ADD);
        prog[BASE+3] = HALT_W;
        resetCore();
        runUntilHalt(100, cyc);
        total++; if (cyc !== 14) begin bad++; $display("FAIL alu_cycles got=%0d want=14", cyc); end
        readReg(5'd3, v);
        total++; if (v !== 32'd12) begin bad++; $display("FAIL alu_r3 got=%h want=c", v); end
        readReg(5'd1, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL alu_r1 got=%h want=5", v); end
        total++; if (halted !== 1'b1 || illegal !== 1'b0) begin bad++; $display("FAIL alu_halt halted=%b illegal=%b want 1 0", halted, illegal); end
    endtask

    task automatic test_jump();
        int cyc;
        logic [31:0] v;
        ackDelay = 0;
        clearProg();
        prog[BASE+0] = {OP_J, 26'h14};
        prog[BASE+1] = encI(OP_ADDI, 5'd0, 5'd1, 16'd1);
        prog[BASE+4] = encI(OP_ADDI, 5'd0, 5'd2, 16'd2);
        prog[BASE+5] = HALT_W;
        resetCore();
        runUntilHalt(100, cyc);
        total++; if (cyc !== 8) begin bad++; $display("FAIL jump_cycles got=%0d want=8", cyc); end
        readReg(5'd1, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL jump_skipped_r1 got=%h want=0", v); end
        readReg(5'd2, v);
        total++; if (v !== 32'd2) begin bad++; $display("FAIL jump_target_r2 got=%h want=2", v); end
    endtask

    task automatic test_mem_wait();
        int cyc;
        logic [31:0] v;
        ackDelay = 3;
        clearProg();
        prog[BASE+0] = encI(OP_ADDI, 5'd0, 5'd3, 16'd12);
        prog[BASE+1] = encI(OP_SW, 5'd0, 5'd3, 16'd8);
        prog[BASE+2] = encI(OP_LW, 5'd0, 5'd4, 16'd8);
        prog[BASE+3] = HALT_W;
        resetCore();
        runUntilHalt(200, cyc);
        total++; if (cyc !== 33) begin bad++; $display("FAIL memwait_cycles got=%0d want=33", cyc); end
        total++; if (wrCount !== 1) begin bad++; $display("FAIL memwait_wrcount got=%0d want=1", wrCount); end
        total++; if (lastWrAddr !== 32'd8 || lastWrData !== 32'd12) begin bad++; $display("FAIL memwait_store addr=%h data=%h want 8 c", lastWrAddr, lastWrData); end
        readReg(5'd4, v);
        total++; if (v !== 32'd12) begin bad++; $display("FAIL memwait_lw_r4 got=%h want=c", v); end
        ackDelay = 0;
    endtask

    task automatic test_branch();
        logic [31:0] v;
        ackDelay = 0;
        clearProg();
        prog[BASE+0] = encI(OP_ADDI, 5'd0, 5'd1, 16'd3);
        prog[BASE+1] = encI(OP_BEQ, 5'd1, 5'd0, 16'd5);
        prog[BASE+2] = encI(OP_ADDI, 5'd0, 5'd2, 16'd9);
        prog[BASE+3] = encI(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
        resetCore();
        runCycles(11);
        total++; if (memReq !== 1'b1 || memAddr !== 32'h4C) begin bad++; $display("FAIL beq_not_taken req=%b addr=%h want 1 4c", memReq, memAddr); end
        readReg(5'd2, v);
        total++; if (v !== 32'd9) begin bad++; $display("FAIL beq_fallthrough_r2 got=%h want=9", v); end
        runCycles(3);
        total++; if (memReq !== 1'b1 || memAddr !== 32'h4C) begin bad++; $display("FAIL beq_taken_loop1 req=%b addr=%h want 1 4c", memReq, memAddr); end
        runCycles(3);
        total++; if (memReq !== 1'b1 || memAddr !== 32'h4C || halted !== 1'b0) begin bad++; $display("FAIL beq_taken_loop2 req=%b addr=%h halted=%b want 1 4c 0", memReq, memAddr, halted); end
    endtask

    task automatic test_signed();
        int cyc;
        logic [31:0] v;
        ackDelay = 0;
        clearProg();
        prog[1]      = 32'h7FFF_FFFF;
        prog[BASE+0] = encI(OP_ADDI, 5'd0, 5'd5, 16'hFFFF);
        prog[BASE+1] = encR(5'd5, 5'd0, 5'd6, FN_SLT);
        prog[BASE+2] = encI(OP_LW, 5'd0, 5'd7, 16'd4);
        prog[BASE+3] = encI(OP_ADDI, 5'd0, 5'd8, 16'd1);
        prog[BASE+4] = encR(5'd7, 5'd8, 5'd9, FN_ADD);
        prog[BASE+5] = encR(5'd0, 5'd8, 5'd10, FN_SUB);
        prog[BASE+6] = encR(5'd7, 5'd5, 5'd11, FN_AND);
        prog[BASE+7] = encR(5'd9, 5'd8, 5'd12, FN_OR);
        prog[BASE+8] = encR(5'd0, 5'd5, 5'd13, FN_SLT);
        prog[BASE+9] = HALT_W;
        resetCore();
        runUntilHalt(200, cyc);
        total++; if (cyc !== 39) begin bad++; $display("FAIL signed_cycles got=%0d want=39", cyc); end
        readReg(5'd5, v);
        total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL signed_r5 got=%h want=ffffffff", v); end
        readReg(5'd6, v);
        total++; if (v !== 32'd1) begin bad++; $display("FAIL slt_neg_r6 got=%h want=1", v); end
        readReg(5'd9, v);
        total++; if (v !== 32'h8000_0000) begin bad++; $display("FAIL add_wrap_r9 got=%h want=80000000", v); end
        readReg(5'd10, v);
        total++; if (v !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sub_r10 got=%h want=ffffffff", v); end
        readReg(5'd11, v);
        total++; if (v !== 32'h7FFF_FFFF) begin bad++; $display("FAIL and_r11 got=%h want=7fffffff", v); end
        readReg(5'd12, v);
        total++; if (v !== 32'h8000_0001) begin bad++; $display("FAIL or_r12 got=%h want=80000001", v); end
        readReg(5'd13, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL slt_pos_r13 got=%h want=0", v); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL signed_no_trap got=%b want=0", illegal); end
    endtask

    task automatic test_r0_illegal();
        int cyc;
        logic [31:0] v;
        ackDelay = 0;
        clearProg();
        prog[BASE+0] = encI(OP_ADDI, 5'd0, 5'd0, 16'd9);
        prog[BASE+1] = ILL_W;
        prog[BASE+2] = encI(OP_ADDI, 5'd0, 5'd7, 16'd4);
        prog[BASE+3] = HALT_W;
        resetCore();
        runUntilHalt(100, cyc);
        total++; if (cyc !== 6) begin bad++; $display("FAIL illegal_cycles got=%0d want=6", cyc); end
        total++; if (halted !== 1'b1 || illegal !== 1'b1) begin bad++; $display("FAIL illegal_flags halted=%b illegal=%b want 1 1", halted, illegal); end
        readReg(5'd0, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL r0_write_discard got=%h want=0", v); end
        for (int i = 0; i < 4; i++) begin
            runCycles(1);
            total++; if (memReq !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL halt_absorbing cycle=%0d req=%b halted=%b want 0 1", i, memReq, halted); end
        end
        readReg(5'd7, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL illegal_no_continue_r7 got=%h want=0", v); end
        runCycles(2);
        total++; if (halted2 !== 1'b1 || illegal2 !== 1'b0) begin bad++; $display("FAIL nop_mode_flags halted=%b illegal=%b want 1 0", halted2, illegal2); end
        readReg2(5'd7, v);
        total++; if (v !== 32'd4) begin bad++; $display("FAIL nop_mode_r7 got=%h want=4", v); end
    endtask

    task automatic test_reset_mid_fetch();
        int cyc;
        logic [31:0] v;
        ackDelay = 0;
        clearProg();
        prog[BASE+0] = encI(OP_ADDI, 5'd0, 5'd1, 16'd5);
        prog[BASE+1] = encI(OP_ADDI, 5'd0, 5'd2, 16'd6);
        prog[BASE+2] = HALT_W;
        resetCore();
        runCycles(4);
        ackDelay = 20;
        runCycles(2);
        total++; if (memReq !== 1'b1 || memAddr !== 32'h44) begin bad++; $display("FAIL wait_stable req=%b addr=%h want 1 44", memReq, memAddr); end
        readReg(5'd1, v);
        total++; if (v !== 32'd5) begin bad++; $display("FAIL prefetch_r1 got=%h want=5", v); end
        rst = 1'b1;
        forceAck = 1'b1;
        #1;
        total++; if (memReq !== 1'b0) begin bad++; $display("FAIL rst_drops_req got=%b want=0", memReq); end
        @(posedge clk);
        #1 rst = 1'b0;
        forceAck = 1'b0;
        #1;
        total++; if (memReq !== 1'b1 || memAddr !== 32'h40) begin bad++; $display("FAIL refetch req=%b addr=%h want 1 40", memReq, memAddr); end
        readReg(5'd1, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL rst_clears_r1 got=%h want=0", v); end
        ackDelay = 0;
        runUntilHalt(100, cyc);
        total++; if (cyc !== 10) begin bad++; $display("FAIL after_rst_cycles got=%0d want=10", cyc); end
        readReg(5'd2, v);
        total++; if (v !== 32'd6) begin bad++; $display("FAIL after_rst_r2 got=%h want=6", v); end
    endtask

    initial begin
        rst = 1'b1;
        forceAck = 1'b0;
        ackDelay = 0;
        dbgAddr = 5'd0;
        dbgAddr2 = 5'd0;
        test_reset();
        test_alu_prog();
        test_jump();
        test_mem_wait();
        test_branch();
        test_signed();
        test_r0_illegal();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
